vc_input_unit: RTL

//  Parametrised router input port with NUM_VC virtual channels, each with its own flit FIFO.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/vc_input_unit_fifo.sv | 58 +++++
 rtl/vc_input_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router input unit.
//   flit type encodings (top two bits of a flit)
//   one-hot output-port constants {L,S,N,W,E}, bit0 = E
//   per-VC control FSM state enum
//   bit offset of the destination X field inside a head flit
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b11;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [1:0] FLIT_INV  = 2'b00;

  localparam logic [4:0] PORT_E = 5'b00001;
  localparam logic [4:0] PORT_W = 5'b00010;
  localparam logic [4:0] PORT_N = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  // Destination Y sits directly above X: Y LSB = DEST_X_LSB + COORD_W.
  localparam int DEST_X_LSB = 6;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_ROUTE   = 2'd1,
    VC_VA_WAIT = 2'd2,
    VC_ACTIVE  = 2'd3
  } vc_state_e;

endpackage

// File: rtl/vc_input_unit_fifo.sv
// Per-VC flit FIFO with a combinational front read.
//   clk, reset (async, active low)
//   push/din  : write; accepted when not full, or when full and popping this cycle
//   pop       : removes the front entry (ignored when empty)
//   front     : current front entry, valid while !empty
//   full/empty: occupancy flags
module vc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign front   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: NUM_VC virtual channels, each with a flit FIFO and a
// route / VC-allocation / switch-request control FSM; round-robin switch
// request across active VCs; credit pulse upstream per departing flit.
//   clk, reset (async, active low)
//   X_cur, Y_cur         : this router's mesh coordinates
//   in_valid/in_vc/in_flit : incoming flit and its target VC
//   credit_out           : per-VC pulse when a flit leaves that FIFO
//   va_req/va_port       : per-VC downstream VC request and one-hot out port
//   va_grant/va_out_vc   : per-VC grant and granted downstream VC
//   sa_req/sa_vc/sa_port/sa_out_vc/sa_flit : switch request of the selected VC
//   sa_grant             : pops the selected VC this cycle
//   err                  : sticky overflow / protocol violation flag
//
// Per-VC FSM:
//   state      | meaning
//   VC_IDLE    | waiting for a head at the FIFO front; non-head fronts are dropped
//   VC_ROUTE   | one cycle: XY route of the head, port latched
//   VC_VA_WAIT | va_req high until va_grant, then downstream VC latched
//   VC_ACTIVE  | switch-eligible while non-empty; popping a tail returns to idle
module vc_input_unit
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 64,
  parameter int NUM_VC  = 2,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 3,
  localparam int VC_W   = $clog2(NUM_VC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     X_cur,
  input  logic [COORD_W-1:0]     Y_cur,
  input  logic                   in_valid,
  input  logic [VC_W-1:0]        in_vc,
  input  logic [FLIT_W-1:0]      in_flit,
  output logic [NUM_VC-1:0]      credit_out,
  output logic [NUM_VC-1:0]      va_req,
  output logic [5*NUM_VC-1:0]    va_port,
  input  logic [NUM_VC-1:0]      va_grant,
  input  logic [VC_W*NUM_VC-1:0] va_out_vc,
  output logic                   sa_req,
  output logic [VC_W-1:0]        sa_vc,
  output logic [4:0]             sa_port,
  output logic [VC_W-1:0]        sa_out_vc,
  output logic [FLIT_W-1:0]      sa_flit,
  input  logic                   sa_grant,
  output logic                   err
);

  localparam int DEST_Y_LSB = DEST_X_LSB + COORD_W;

  function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy,
                                          input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    if (dx > cx)      return PORT_E;
    else if (dx < cx) return PORT_W;
    else if (dy > cy) return PORT_N;
    else if (dy < cy) return PORT_S;
    else              return PORT_L;
  endfunction

  vc_state_e         state      [NUM_VC];
  logic [4:0]        port_q     [NUM_VC];
  logic [VC_W-1:0]   out_vc_q   [NUM_VC];
  logic [FLIT_W-1:0] front      [NUM_VC];
  logic [1:0]        front_type [NUM_VC];
  logic [4:0]        route_port [NUM_VC];

  logic [NUM_VC-1:0] full, empty, push, pop, discard, sa_pop, elig, ovf;
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   sel_vc;
  logic              sel_found;
  logic [1:0]        in_type;

  assign in_type = in_flit[FLIT_W-1 -: 2];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (in_flit),
      .front (front[v]),
      .full  (full[v]),
      .empty (empty[v])
    );

    assign front_type[v] = front[v][FLIT_W-1 -: 2];
    assign route_port[v] = xy_route(front[v][DEST_X_LSB +: COORD_W], front[v][DEST_Y_LSB +: COORD_W],
                                    X_cur, Y_cur);
    assign push[v]    = in_valid && (in_vc == VC_W'(v)) && (in_type != FLIT_INV);
    // An idle VC can only make progress on a head; anything else is stale and dropped.
    assign discard[v] = (state[v] == VC_IDLE) && !empty[v] && (front_type[v] != FLIT_HEAD);
    assign elig[v]    = (state[v] == VC_ACTIVE) && !empty[v];
    assign sa_pop[v]  = sa_grant && sel_found && (sel_vc == VC_W'(v));
    assign pop[v]     = discard[v] | sa_pop[v];
    assign ovf[v]     = push[v] && full[v] && !pop[v];
    assign va_req[v]  = (state[v] == VC_VA_WAIT);
    assign va_port[v*5 +: 5] = port_q[v];
  end

  assign credit_out = pop;

  // Round-robin pick: first eligible VC at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_vc    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!sel_found && elig[idx[VC_W-1:0]]) begin
        sel_found = 1'b1;
        sel_vc    = idx[VC_W-1:0];
      end
    end
  end

  always_comb begin
    sa_req    = sel_found;
    sa_vc     = '0;
    sa_port   = '0;
    sa_out_vc = '0;
    sa_flit   = '0;
    if (sel_found) begin
      sa_vc     = sel_vc;
      sa_port   = port_q[sel_vc];
      sa_out_vc = out_vc_q[sel_vc];
      sa_flit   = front[sel_vc];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state[v]    <= VC_IDLE;
        port_q[v]   <= '0;
        out_vc_q[v] <= '0;
      end
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case (state[v])
          VC_IDLE:
            if (!empty[v] && front_type[v] == FLIT_HEAD) state[v] <= VC_ROUTE;
          VC_ROUTE: begin
            port_q[v] <= route_port[v];
            state[v]  <= VC_VA_WAIT;
          end
          VC_VA_WAIT:
            if (va_grant[v]) begin
              out_vc_q[v] <= va_out_vc[v*VC_W +: VC_W];
              state[v]    <= VC_ACTIVE;
            end
          VC_ACTIVE:
            // A stray head mid-packet is forwarded like a body; only a tail ends the packet.
            if (sa_pop[v] && front_type[v] == FLIT_TAIL) state[v] <= VC_IDLE;
          default: state[v] <= VC_IDLE;
        endcase
      end
      if (sa_grant && sel_found)
        rr_ptr <= (sel_vc == VC_W'(NUM_VC - 1)) ? '0 : sel_vc + 1'b1;
      if (|discard || |ovf) err <= 1'b1;
    end
  end

endmodule
